mutex_requester_2ch: RTL and testbench

//  Synchronous client for the 2-input NAND-latch mutex arbiter.
//  - Drives the mutex request inputs X1/X0 using a 4-phase handshake.
//  - Consumes the asynchronous grants Y1/Y0 through synchronizers.
//  - Holds each grant for a programmed number of cycles (critical section), then releases.
//  - Counts grants and flags mutual-exclusion and spurious-grant violations.

---
 rtl/mutex_requester_2ch.sv | 203 ++++++++++++++++++++
 tb/tb_mutex_requester_2ch.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mutex_requester_2ch.sv
// Two-channel synchronous client for a NAND-latch mutex: 4-phase request/grant
// handshake per channel, timed critical section, grant counters and error flags.

module mutex_requester_ch #(
  parameter int unsigned HOLD_W      = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [HOLD_W-1:0] hold_i,
  input  logic              y_i,
  output logic              x_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              ys_o,
  output logic              inactive_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_REL  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ys;
  logic [2:0]             state_q, state_d;
  logic [HOLD_W-1:0]      hc_q, hc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   x_q, x_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   inactive_q, inactive_d;

  // Grant synchronizer; the mutex output is asynchronous to clk_i.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], y_i};
    end
  end

  assign ys = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      hc_q       <= '0;
      cnt_q      <= '0;
      x_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      inactive_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      hc_q       <= hc_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      inactive_q <= inactive_d;
    end
  end

  // Handshake sequencing; outputs are decoded from the next state so they align with state_q.
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_REQ;
          hc_d    = hold_i;
        end
      end
      S_REQ: begin
        if (ys) begin
          state_d = S_HOLD;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (hc_q == '0) begin
          state_d = S_REL;
        end else begin
          hc_d = hc_q - HOLD_W'(1);
        end
      end
      S_REL: begin
        if (!ys) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    x_d        = (state_d == S_REQ) || (state_d == S_HOLD);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    inactive_d = (state_d == S_IDLE) || (state_d == S_DONE);
  end

  assign x_o        = x_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign cnt_o      = cnt_q;
  assign ys_o       = ys;
  assign inactive_o = inactive_q;

endmodule

module mutex_requester_2ch #(
  parameter int unsigned HOLD_W      = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start1_i,
  input  logic              start0_i,
  input  logic [HOLD_W-1:0] hold1_i,
  input  logic [HOLD_W-1:0] hold0_i,
  output logic              x1_o,
  output logic              x0_o,
  input  logic              y1_i,
  input  logic              y0_i,
  output logic              busy1_o,
  output logic              busy0_o,
  output logic              done1_o,
  output logic              done0_o,
  output logic [CNT_W-1:0]  gnt_cnt1_o,
  output logic [CNT_W-1:0]  gnt_cnt0_o,
  output logic              err_excl_o,
  output logic              err_spur_o,
  input  logic              clr_err_i
);

  logic ys1, ys0;
  logic inact1, inact0;
  logic excl_q, excl_d;
  logic spur_q, spur_d;

  mutex_requester_ch #(
    .HOLD_W      (HOLD_W),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ch1 (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (start1_i),
    .hold_i     (hold1_i),
    .y_i        (y1_i),
    .x_o        (x1_o),
    .busy_o     (busy1_o),
    .done_o     (done1_o),
    .cnt_o      (gnt_cnt1_o),
    .ys_o       (ys1),
    .inactive_o (inact1)
  );

  mutex_requester_ch #(
    .HOLD_W      (HOLD_W),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ch0 (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (start0_i),
    .hold_i     (hold0_i),
    .y_i        (y0_i),
    .x_o        (x0_o),
    .busy_o     (busy0_o),
    .done_o     (done0_o),
    .cnt_o      (gnt_cnt0_o),
    .ys_o       (ys0),
    .inactive_o (inact0)
  );

  // Sticky error flags; a set condition overrides a simultaneous clear.
  always_comb begin
    excl_d = (ys1 & ys0) | (excl_q & ~clr_err_i);
    spur_d = (ys1 & inact1) | (ys0 & inact0) | (spur_q & ~clr_err_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      excl_q <= 1'b0;
      spur_q <= 1'b0;
    end else begin
      excl_q <= excl_d;
      spur_q <= spur_d;
    end
  end

  assign err_excl_o = excl_q;
  assign err_spur_o = spur_q;

endmodule

// File: tb/tb_mutex_requester_2ch.sv
// Bench for mutex_requester_2ch: mutex environment model plus a per-channel
// handshake reference model, compared every cycle and at scenario boundaries.

module tb_mutex_requester_2ch;

  localparam int unsigned HOLD_W = 8;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned SS     = 2;
  localparam int unsigned OW     = 8 + 2 * CNT_W;
  localparam int P_IDLE = 0, P_REQ = 1, P_HOLD = 2, P_REL = 3, P_DONE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0, start0 = 1'b0;
  logic [HOLD_W-1:0] hold1 = '0, hold0 = '0;
  logic y1 = 1'b0, y0 = 1'b0;
  logic clr = 1'b0;
  logic x1, x0, busy1, busy0, done1, done0, excl, spur;
  logic [CNT_W-1:0] cnt1, cnt0;

  int checks = 0;
  int passes = 0;

  // reference model state
  int ph [2];
  int rem [2];
  int mcnt [2];
  bit sy [2][SS];
  bit m_excl, m_spur;

  // mutex environment
  bit auto_mutex;
  int owner;
  int gwait;
  int gdly;
  bit rand_dly;
  bit prefer0;
  bit yf1, yf0;

  always #5 clk = ~clk;

  mutex_requester_2ch #(
    .HOLD_W      (HOLD_W),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SS)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start1_i   (start1),
    .start0_i   (start0),
    .hold1_i    (hold1),
    .hold0_i    (hold0),
    .x1_o       (x1),
    .x0_o       (x0),
    .y1_i       (y1),
    .y0_i       (y0),
    .busy1_o    (busy1),
    .busy0_o    (busy0),
    .done1_o    (done1),
    .done0_o    (done0),
    .gnt_cnt1_o (cnt1),
    .gnt_cnt0_o (cnt0),
    .err_excl_o (excl),
    .err_spur_o (spur),
    .clr_err_i  (clr)
  );

  function automatic logic [OW-1:0] obs();
    return {x1, x0, busy1, busy0, done1, done0, cnt1, cnt0, excl, spur};
  endfunction

  function automatic logic [OW-1:0] expv();
    logic [CNT_W-1:0] c1, c0;
    c1 = CNT_W'(mcnt[1]);
    c0 = CNT_W'(mcnt[0]);
    return {(ph[1] == P_REQ || ph[1] == P_HOLD), (ph[0] == P_REQ || ph[0] == P_HOLD),
            (ph[1] != P_IDLE), (ph[0] != P_IDLE),
            (ph[1] == P_DONE), (ph[0] == P_DONE),
            c1, c0, m_excl, m_spur};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      ph[c] = P_IDLE;
      rem[c] = 0;
      mcnt[c] = 0;
      for (int i = 0; i < int'(SS); i++) sy[c][i] = 1'b0;
    end
    m_excl = 1'b0;
    m_spur = 1'b0;
  endtask

  // Advance the reference by one clock edge using pre-edge inputs.
  task automatic model_adv();
    bit ys [2];
    bit st;
    int hd;
    ys[1] = sy[1][SS-1];
    ys[0] = sy[0][SS-1];
    m_excl = (ys[1] && ys[0]) || (m_excl && !clr);
    m_spur = (ys[1] && (ph[1] == P_IDLE || ph[1] == P_DONE)) ||
             (ys[0] && (ph[0] == P_IDLE || ph[0] == P_DONE)) || (m_spur && !clr);
    for (int c = 0; c < 2; c++) begin
      st = (c == 1) ? start1 : start0;
      hd = (c == 1) ? int'(hold1) : int'(hold0);
      case (ph[c])
        P_IDLE: if (st) begin ph[c] = P_REQ; rem[c] = hd; end
        P_REQ:  if (ys[c]) begin ph[c] = P_HOLD; mcnt[c] = (mcnt[c] + 1) % (1 << CNT_W); end
        P_HOLD: if (rem[c] == 0) ph[c] = P_REL; else rem[c] = rem[c] - 1;
        P_REL:  if (!ys[c]) ph[c] = P_DONE;
        default: ph[c] = P_IDLE;
      endcase
    end
    for (int c = 0; c < 2; c++) begin
      for (int i = int'(SS) - 1; i > 0; i--) sy[c][i] = sy[c][i-1];
      sy[c][0] = (c == 1) ? y1 : y0;
    end
  endtask

  // One clock: mutex reacts to current requests, model advances, DUT clocks.
  task automatic step();
    if (auto_mutex) begin
      if (owner == 1 && !x1) owner = -1;
      if (owner == 0 && !x0) owner = -1;
      if (owner < 0 && (x1 || x0)) begin
        if (gwait > 0) gwait--;
        else begin
          if (x1 && x0) owner = prefer0 ? 0 : 1;
          else owner = x0 ? 0 : 1;
          gwait = rand_dly ? int'($urandom_range(0, 2)) : gdly;
          if (rand_dly) prefer0 = bit'($urandom_range(0, 1));
        end
      end
      y1 = (owner == 1);
      y0 = (owner == 0);
    end else begin
      y1 = yf1;
      y0 = yf0;
    end
    model_adv();
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    start1 = 1'b0; start0 = 1'b0; clr = 1'b0;
    hold1 = '0; hold0 = '0;
    y1 = 1'b0; y0 = 1'b0; yf1 = 1'b0; yf0 = 1'b0;
    owner = -1; gwait = 0; gdly = 0; rand_dly = 1'b0; prefer0 = 1'b0; auto_mutex = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_all();
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== '0) $display("FAIL reset_state obs=%h exp=0", obs());
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs() !== expv()) $display("FAIL reset_idle cyc=%0d obs=%h exp=%h", i, obs(), expv());
      else passes++;
    end
  endtask

  task automatic test_single();
    int xh, dn;
    reset_all();
    gdly = 2; gwait = 2;
    xh = 0; dn = 0;
    hold1 = HOLD_W'(3);
    start1 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      start1 = 1'b0;
      if (x1) xh++;
      if (done1) dn++;
      checks++;
      if (obs() !== expv()) $display("FAIL single cyc=%0d obs=%h exp=%h", i, obs(), expv());
      else passes++;
    end
    checks++;
    if (xh !== 9) $display("FAIL single_x1_cycles obs=%0d exp=9", xh); else passes++;
    checks++;
    if (dn !== 1) $display("FAIL single_done_pulses obs=%0d exp=1", dn); else passes++;
    checks++;
    if (cnt1 !== CNT_W'(1)) $display("FAIL single_cnt obs=%0d exp=1", cnt1); else passes++;
    checks++;
    if ({excl, spur} !== 2'b00) $display("FAIL single_err obs=%b exp=00", {excl, spur}); else passes++;
  endtask

  task automatic test_contention();
    int d0, d1;
    reset_all();
    prefer0 = 1'b1;
    d0 = -1; d1 = -1;
    hold1 = HOLD_W'(5); hold0 = HOLD_W'(5);
    start1 = 1'b1; start0 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      start1 = 1'b0; start0 = 1'b0;
      if (done0 && d0 < 0) d0 = i;
      if (done1 && d1 < 0) d1 = i;
      checks++;
      if (obs() !== expv()) $display("FAIL contention cyc=%0d obs=%h exp=%h", i, obs(), expv());
      else passes++;
    end
    checks++;
    if ((d0 >= 0 && d1 > d0) !== 1'b1) $display("FAIL contention_order done0@%0d done1@%0d exp ch0 first", d0, d1);
    else passes++;
    checks++;
    if ({cnt1, cnt0} !== {CNT_W'(1), CNT_W'(1)}) $display("FAIL contention_cnt obs=%0d/%0d exp=1/1", cnt1, cnt0);
    else passes++;
    checks++;
    if (excl !== 1'b0) $display("FAIL contention_excl obs=%b exp=0", excl); else passes++;
  endtask

  task automatic test_spur();
    reset_all();
    auto_mutex = 1'b0;
    yf0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs() !== expv()) $display("FAIL spur_set cyc=%0d obs=%h exp=%h", i, obs(), expv());
      else passes++;
    end
    checks++;
    if (spur !== 1'b1) $display("FAIL spur_flag obs=%b exp=1", spur); else passes++;
    yf0 = 1'b0;
    repeat (3) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if ({excl, spur} !== 2'b00) $display("FAIL spur_clear obs=%b exp=00", {excl, spur}); else passes++;
  endtask

  task automatic test_excl();
    reset_all();
    auto_mutex = 1'b0;
    yf1 = 1'b1; yf0 = 1'b1;
    repeat (4) step();
    checks++;
    if (excl !== 1'b1) $display("FAIL excl_flag obs=%b exp=1", excl); else passes++;
    clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs() !== expv()) $display("FAIL excl_clr_forced cyc=%0d obs=%h exp=%h", i, obs(), expv());
      else passes++;
    end
    checks++;
    if (excl !== 1'b1) $display("FAIL excl_sticky obs=%b exp=1", excl); else passes++;
    yf1 = 1'b0; yf0 = 1'b0;
    repeat (3) step();
    clr = 1'b0;
    checks++;
    if ({excl, spur} !== 2'b00) $display("FAIL excl_clear obs=%b exp=00", {excl, spur}); else passes++;
  endtask

  task automatic test_reset_mid();
    int n;
    reset_all();
    hold1 = HOLD_W'(20);
    start1 = 1'b1;
    n = 0;
    while (ph[1] != P_HOLD && n < 20) begin
      step();
      start1 = 1'b0;
      n++;
    end
    repeat (2) step();
    checks++;
    if ({x1, busy1, cnt1} !== {1'b1, 1'b1, CNT_W'(1)})
      $display("FAIL midrst_before obs=%b%b/%0d exp=11/1", x1, busy1, cnt1);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({x1, busy1, cnt1} !== {1'b0, 1'b0, CNT_W'(0)})
      $display("FAIL midrst_async obs=%b%b/%0d exp=00/0", x1, busy1, cnt1);
    else passes++;
    owner = -1; y1 = 1'b0; y0 = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs() !== expv()) $display("FAIL midrst_after cyc=%0d obs=%h exp=%h", i, obs(), expv());
      else passes++;
    end
  endtask

  task automatic test_wrap();
    int exp_seq [5] = '{1, 2, 3, 0, 1};
    int n;
    reset_all();
    hold1 = HOLD_W'(1);
    for (int r = 0; r < 5; r++) begin
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      step();
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      checks++;
      if (obs() !== expv()) $display("FAIL wrap_ignored_start run=%0d obs=%h exp=%h", r, obs(), expv());
      else passes++;
      n = 0;
      while (ph[1] != P_IDLE && n < 40) begin
        step();
        n++;
      end
      checks++;
      if (n >= 40) $display("FAIL wrap_timeout run=%0d", r);
      else if (cnt1 !== CNT_W'(exp_seq[r])) $display("FAIL wrap_cnt run=%0d obs=%0d exp=%0d", r, cnt1, exp_seq[r]);
      else passes++;
    end
  endtask

  task automatic test_random();
    reset_all();
    rand_dly = 1'b1;
    for (int i = 0; i < 500; i++) begin
      start1 = ($urandom_range(0, 3) == 0);
      start0 = ($urandom_range(0, 3) == 0);
      hold1 = HOLD_W'($urandom_range(0, 5));
      hold0 = HOLD_W'($urandom_range(0, 5));
      clr = ($urandom_range(0, 15) == 0);
      step();
      checks++;
      if (obs() !== expv()) $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs(), expv());
      else passes++;
    end
    start1 = 1'b0; start0 = 1'b0; clr = 1'b0;
    repeat (40) step();
    checks++;
    if (obs() !== expv()) $display("FAIL random_drain obs=%h exp=%h", obs(), expv()); else passes++;
    checks++;
    if ({excl, spur} !== 2'b00) $display("FAIL random_err obs=%b exp=00", {excl, spur}); else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_spur();
    test_excl();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
